// File: rtl/obi_fifo_responder.sv
// OBI data-bus responder exposing a word FIFO mailbox with status, threshold
// interrupt and flush control. One outstanding transaction, response one cycle after grant.
module obi_fifo_responder #(
  parameter int unsigned DEPTH          = 8,
  parameter int unsigned GNT_WAIT       = 0,
  parameter int unsigned ADDR_LSB_WIDTH = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_i,
  output logic        gnt_o,
  input  logic [31:0] addr_i,
  input  logic        we_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] wdata_i,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        err_o,
  output logic        irq_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned WW = $clog2(GNT_WAIT + 2);

  typedef enum logic [1:0] {
    REG_DATA   = 2'd0,
    REG_STATUS = 2'd1,
    REG_THRESH = 2'd2,
    REG_CTRL   = 2'd3
  } reg_e;

  logic [WW-1:0] wait_q, wait_d;
  logic [PW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] count_q, count_d;
  logic [15:0]   thresh_q, thresh_d;
  logic          rvalid_q, err_q, irq_q;
  logic [31:0]   rdata_q;
  logic [31:0]   mem_q [DEPTH];

  logic          gnt, push, pop, flush, resp_err, full, empty, in_range;
  logic [31:0]   resp_data;
  reg_e          sel;
  logic          unused_addr;

  assign unused_addr = ^addr_i[31:ADDR_LSB_WIDTH];

  assign gnt      = rst_ni && req_i && (wait_q == WW'(GNT_WAIT));
  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == '0);
  // Offsets beyond the four registers (only possible with a wider decode) are errors.
  assign in_range = ((addr_i[ADDR_LSB_WIDTH-1:2] >> 2) == '0);
  assign sel      = reg_e'(addr_i[3:2]);

  always_comb begin
    push      = 1'b0;
    pop       = 1'b0;
    flush     = 1'b0;
    resp_err  = 1'b0;
    resp_data = '0;
    thresh_d  = thresh_q;
    if (gnt) begin
      if (addr_i[1:0] != 2'b00 || !in_range) begin
        resp_err = 1'b1;
      end else begin
        unique case (sel)
          REG_DATA: begin
            if (we_i) begin
              if (be_i != 4'hF || full) resp_err = 1'b1;
              else                      push     = 1'b1;
            end else if (empty) begin
              resp_err = 1'b1;
            end else begin
              pop       = 1'b1;
              resp_data = mem_q[rptr_q];
            end
          end
          REG_STATUS: begin
            if (we_i) resp_err  = 1'b1;
            else      resp_data = {14'd0, full, empty, 16'(count_q)};
          end
          REG_THRESH: begin
            if (we_i) begin
              if (be_i != 4'hF) resp_err = 1'b1;
              else              thresh_d = wdata_i[15:0];
            end else begin
              resp_data = {16'd0, thresh_q};
            end
          end
          REG_CTRL: begin
            if (we_i) flush = wdata_i[0];
          end
          default: resp_err = 1'b1;
        endcase
      end
    end
  end

  always_comb begin
    count_d = count_q;
    if (flush)     count_d = '0;
    else if (push) count_d = count_q + 1'b1;
    else if (pop)  count_d = count_q - 1'b1;
  end

  always_comb begin
    wait_d = wait_q + 1'b1;
    if (!req_i || gnt) wait_d = '0;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wait_q   <= '0;
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
      thresh_q <= '0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      wait_q   <= wait_d;
      count_q  <= count_d;
      thresh_q <= thresh_d;
      rvalid_q <= gnt;
      rdata_q  <= resp_data;
      err_q    <= resp_err;
      irq_q    <= (thresh_d != '0) && (16'(count_d) >= thresh_d);
      if (flush) begin
        wptr_q <= '0;
        rptr_q <= '0;
      end else begin
        if (push) wptr_q <= wptr_q + 1'b1;
        if (pop)  rptr_q <= rptr_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wptr_q] <= wdata_i;
  end

  // Reset masks the registered response so a pending one is never presented.
  assign gnt_o    = gnt;
  assign rvalid_o = rst_ni && rvalid_q;
  assign rdata_o  = rst_ni ? rdata_q : '0;
  assign err_o    = rst_ni && err_q;
  assign irq_o    = rst_ni && irq_q;

endmodule

// File: tb/tb_obi_fifo_responder.sv
// Bench for obi_fifo_responder: two instances (immediate and delayed grant) checked
// every cycle against a queue-based transaction model, plus directed literal checks.
module tb_obi_fifo_responder;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n [2];
  logic        req   [2];
  logic        we    [2];
  logic [31:0] addr  [2];
  logic [3:0]  be    [2];
  logic [31:0] wdata [2];
  logic        gnt   [2];
  logic        rvalid[2];
  logic [31:0] rdata [2];
  logic        err   [2];
  logic        irq   [2];

  obi_fifo_responder #(.DEPTH(8), .GNT_WAIT(0), .ADDR_LSB_WIDTH(4)) u_dut0 (
    .clk_i(clk), .rst_ni(rst_n[0]), .req_i(req[0]), .gnt_o(gnt[0]), .addr_i(addr[0]),
    .we_i(we[0]), .be_i(be[0]), .wdata_i(wdata[0]), .rvalid_o(rvalid[0]),
    .rdata_o(rdata[0]), .err_o(err[0]), .irq_o(irq[0]));

  obi_fifo_responder #(.DEPTH(4), .GNT_WAIT(2), .ADDR_LSB_WIDTH(4)) u_dut1 (
    .clk_i(clk), .rst_ni(rst_n[1]), .req_i(req[1]), .gnt_o(gnt[1]), .addr_i(addr[1]),
    .we_i(we[1]), .be_i(be[1]), .wdata_i(wdata[1]), .rvalid_o(rvalid[1]),
    .rdata_o(rdata[1]), .err_o(err[1]), .irq_o(irq[1]));

  int checks = 0;
  int errors = 0;

  function automatic int dep(input int i);
    return (i == 0) ? 8 : 4;
  endfunction

  function automatic int gw(input int i);
    return (i == 0) ? 0 : 2;
  endfunction

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h t=%0t", name, act, exp, $time);
    end
  endfunction

  // Transaction-level model: FIFO contents as a queue, registers as plain variables.
  int unsigned mq [2][$];
  int unsigned mth [2];
  int          mw  [2];
  bit          mrv [2];
  bit          merr[2];
  bit          mirq[2];
  logic [31:0] mrd [2];
  bit          egnt[2];

  function automatic void apply(input int i, input bit w, input logic [31:0] a,
                                input logic [3:0] b, input logic [31:0] d);
    int sz;
    sz      = mq[i].size();
    mrd[i]  = 32'd0;
    merr[i] = 1'b0;
    if (a[1:0] != 2'b00) merr[i] = 1'b1;
    else case (a[3:2])
      2'd0: if (w) begin
              if (b != 4'hF || sz == dep(i)) merr[i] = 1'b1;
              else mq[i].push_back(d);
            end else begin
              if (sz == 0) merr[i] = 1'b1;
              else mrd[i] = mq[i].pop_front();
            end
      2'd1: if (w) merr[i] = 1'b1;
            else mrd[i] = 32'(sz) | ((sz == 0) ? 32'h1_0000 : 32'h0)
                                  | ((sz == dep(i)) ? 32'h2_0000 : 32'h0);
      2'd2: if (w) begin
              if (b != 4'hF) merr[i] = 1'b1;
              else mth[i] = int'(d[15:0]);
            end else mrd[i] = mth[i];
      default: if (w && d[0]) mq[i].delete();
    endcase
  endfunction

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      egnt[i] = rst_n[i] && req[i] && (mw[i] == gw(i));
      chk($sformatf("gnt%0d", i), 32'(gnt[i]), 32'(egnt[i]));
      chk($sformatf("rvalid%0d", i), 32'(rvalid[i]), 32'(rst_n[i] && mrv[i]));
      if (rst_n[i] && mrv[i]) begin
        chk($sformatf("rdata%0d", i), rdata[i], mrd[i]);
        chk($sformatf("err%0d", i), 32'(err[i]), 32'(merr[i]));
      end else if (!rst_n[i]) begin
        chk($sformatf("rst_rdata%0d", i), rdata[i], 32'd0);
        chk($sformatf("rst_err%0d", i), 32'(err[i]), 32'd0);
      end
      chk($sformatf("irq%0d", i), 32'(irq[i]), 32'(rst_n[i] && mirq[i]));
      if (!rst_n[i]) begin
        mq[i].delete();
        mth[i] = 0;
        mw[i]  = 0;
        mrv[i] = 1'b0;
        mirq[i] = 1'b0;
      end else begin
        if (egnt[i]) begin
          apply(i, we[i], addr[i], be[i], wdata[i]);
          mrv[i] = 1'b1;
          mw[i]  = 0;
        end else begin
          mrv[i] = 1'b0;
          mw[i]  = req[i] ? mw[i] + 1 : 0;
        end
        mirq[i] = (mth[i] != 0) && (mq[i].size() >= mth[i]);
      end
    end
  end

  task automatic xact(input int i, input bit w, input logic [31:0] a, input logic [3:0] b,
                      input logic [31:0] d, output logic [31:0] rd, output logic e,
                      output int waitc);
    @(posedge clk); #1;
    req[i] = 1'b1; we[i] = w; addr[i] = a; be[i] = b; wdata[i] = d;
    waitc = 0; rd = '0; e = 1'b0;
    do begin
      @(negedge clk);
      waitc++;
    end while (!gnt[i] && waitc < 20);
    if (!gnt[i]) begin
      chk("gnt_timeout", 32'(gnt[i]), 32'd1);
      @(posedge clk); #1 req[i] = 1'b0;
    end else begin
      @(posedge clk); #1 req[i] = 1'b0;
      @(negedge clk);
      chk("xact_rvalid", 32'(rvalid[i]), 32'd1);
      rd = rdata[i];
      e  = err[i];
    end
  endtask

  task automatic hold(input int i, input int n, input bit w, input logic [31:0] a,
                      input logic [3:0] b, input logic [31:0] d);
    @(posedge clk); #1;
    req[i] = 1'b1; we[i] = w; addr[i] = a; be[i] = b; wdata[i] = d;
    repeat (n) @(negedge clk);
    @(posedge clk); #1 req[i] = 1'b0;
  endtask

  logic [31:0] rd;
  logic        e;
  int          wc;

  initial begin
    for (int i = 0; i < 2; i++) begin
      rst_n[i] = 1'b0; req[i] = 1'b0; we[i] = 1'b0; addr[i] = '0; be[i] = '0; wdata[i] = '0;
      mth[i] = 0; mw[i] = 0; mrv[i] = 1'b0; merr[i] = 1'b0; mirq[i] = 1'b0; mrd[i] = '0;
    end
    repeat (3) @(posedge clk);
    #1 rst_n[0] = 1'b1; rst_n[1] = 1'b1;

    // Immediate grant: write then STATUS.
    xact(0, 1, 32'h0, 4'hF, 32'hDEAD_BEEF, rd, e, wc);
    chk("wr_gnt_cycle", 32'(wc), 32'd1);
    chk("wr_err", 32'(e), 32'd0);
    chk("wr_rdata", rd, 32'd0);
    xact(0, 0, 32'h4, 4'hF, 0, rd, e, wc);
    chk("status_one", rd, 32'h0000_0001);
    xact(0, 0, 32'h0, 4'hF, 0, rd, e, wc);
    chk("pop_beef", rd, 32'hDEAD_BEEF);

    // Fill past full, then drain past empty.
    for (int k = 1; k <= 9; k++) begin
      xact(0, 1, 32'h0, 4'hF, 32'(k), rd, e, wc);
      chk("fill_err", 32'(e), (k == 9) ? 32'd1 : 32'd0);
    end
    xact(0, 0, 32'h4, 4'hF, 0, rd, e, wc);
    chk("status_full", rd, 32'h0002_0008);
    for (int k = 1; k <= 9; k++) begin
      xact(0, 0, 32'h0, 4'hF, 0, rd, e, wc);
      chk("drain_data", rd, (k == 9) ? 32'd0 : 32'(k));
      chk("drain_err", 32'(e), (k == 9) ? 32'd1 : 32'd0);
    end
    xact(0, 0, 32'h4, 4'hF, 0, rd, e, wc);
    chk("status_empty", rd, 32'h0001_0000);

    // Pointer wrap.
    for (int k = 0; k < 6; k++) xact(0, 1, 32'h0, 4'hF, 32'(100 + k), rd, e, wc);
    for (int k = 0; k < 6; k++) begin
      xact(0, 0, 32'h0, 4'hF, 0, rd, e, wc);
      chk("wrap_a", rd, 32'(100 + k));
    end
    for (int k = 0; k < 5; k++) xact(0, 1, 32'h0, 4'hF, 32'(200 + k), rd, e, wc);
    for (int k = 0; k < 5; k++) begin
      xact(0, 0, 32'h0, 4'hF, 0, rd, e, wc);
      chk("wrap_b", rd, 32'(200 + k));
    end
    xact(0, 0, 32'h4, 4'hF, 0, rd, e, wc);
    chk("wrap_status", rd, 32'h0001_0000);

    // Threshold interrupt and flush.
    xact(0, 1, 32'h8, 4'hF, 32'd3, rd, e, wc);
    for (int k = 1; k <= 3; k++) begin
      xact(0, 1, 32'h0, 4'hF, 32'(k), rd, e, wc);
      chk("irq_rise", 32'(irq[0]), (k == 3) ? 32'd1 : 32'd0);
    end
    xact(0, 0, 32'h0, 4'hF, 0, rd, e, wc);
    chk("irq_fall", 32'(irq[0]), 32'd0);
    xact(0, 1, 32'h0, 4'hF, 32'd4, rd, e, wc);
    chk("irq_again", 32'(irq[0]), 32'd1);
    xact(0, 1, 32'hC, 4'hF, 32'd1, rd, e, wc);
    chk("flush_irq", 32'(irq[0]), 32'd0);
    xact(0, 0, 32'h4, 4'hF, 0, rd, e, wc);
    chk("flush_status", rd, 32'h0001_0000);
    xact(0, 1, 32'h8, 4'hF, 32'd0, rd, e, wc);

    // Byte-enable and alignment errors.
    xact(0, 1, 32'h0, 4'hF, 32'd7, rd, e, wc);
    xact(0, 1, 32'h0, 4'h3, 32'd8, rd, e, wc);
    chk("be_err", 32'(e), 32'd1);
    xact(0, 1, 32'h2, 4'hF, 32'd9, rd, e, wc);
    chk("unaligned_err", 32'(e), 32'd1);
    xact(0, 0, 32'h4, 4'hF, 0, rd, e, wc);
    chk("be_status", rd, 32'h0000_0001);

    // Reset in the response cycle.
    @(posedge clk); #1;
    req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h0; be[0] = 4'hF; wdata[0] = 32'h55;
    @(negedge clk);
    chk("rst_gnt", 32'(gnt[0]), 32'd1);
    @(posedge clk); #1 req[0] = 1'b0; rst_n[0] = 1'b0;
    @(negedge clk);
    chk("rst_no_rvalid", 32'(rvalid[0]), 32'd0);
    @(posedge clk); #1 rst_n[0] = 1'b1;
    xact(0, 0, 32'h4, 4'hF, 0, rd, e, wc);
    chk("rst_status", rd, 32'h0001_0000);

    // Delayed grant, then an aborted request.
    xact(1, 1, 32'h0, 4'hF, 32'h1234_5678, rd, e, wc);
    chk("gw2_gnt_cycle", 32'(wc), 32'd3);
    chk("gw2_err", 32'(e), 32'd0);
    hold(1, 2, 1, 32'h0, 4'hF, 32'h1);
    xact(1, 0, 32'h4, 4'hF, 0, rd, e, wc);
    chk("abort_status", rd, 32'h0000_0001);

    // Randomized traffic on both instances; the model checks every cycle.
    for (int n = 0; n < 500; n++) begin
      int          i, pick;
      bit          w;
      logic [31:0] a, d;
      logic [3:0]  b;
      i    = int'($urandom_range(0, 1));
      pick = int'($urandom_range(0, 15));
      w    = 1'($urandom_range(0, 1));
      d    = $urandom;
      b    = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'hF;
      if (pick < 8)       a = 32'h0;
      else if (pick < 10) a = 32'h4;
      else if (pick < 12) begin a = 32'h8; d = 32'($urandom_range(0, dep(i) + 2)); end
      else if (pick < 13) a = 32'hC;
      else                a = 32'(($urandom_range(0, 3) << 2) | $urandom_range(1, 3));
      a = a | ($urandom & 32'hFFFF_FFF0);
      if ($urandom_range(0, 9) == 0) begin
        if (i == 0) hold(0, int'($urandom_range(2, 3)), w, a, b, d);
        else        hold(1, int'($urandom_range(1, 2)), w, a, b, d);
      end else begin
        xact(i, w, a, b, d, rd, e, wc);
      end
    end

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
